irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 4: number of maskable IRQ sources, range 1..8.
REQ-002 Parameter EDGE_MASK [NSRC-1:0], default 4'b0011: per-source mode, 1 = rising-edge latched, 0 = level.
REQ-003 Parameter VEC_BASE [15:0], default 16'hFFF0: IRQ vector base; VEC_BASE+2*(NSRC-1) SHALL be below 16'hFFFA (checked at elaboration).
REQ-004 clock  in  1  system clock (25 MHz); single clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ce  in  1  chip enable; all non-reset state advances only when ce=1.
REQ-007 nmi  in  1  NMI line from PPU, rising-edge sensitive.
REQ-008 irq_in  in  NSRC  IRQ source lines.
REQ-009 mask_we  in  1  write strobe for mask register.
REQ-010 mask_d  in  NSRC  new mask value; 1 = source enabled.
REQ-011 clr_we  in  1  write strobe for pending-clear.
REQ-012 clr_d  in  NSRC  write-1-to-clear pending bits (edge sources only).
REQ-013 i_flag  in  1  CPU interrupt-disable flag.
REQ-014 ack  in  1  CPU accepts the presented request (single-cycle pulse at opcode fetch).
REQ-015 nmi_req  out  1  NMI request to CPU.
REQ-016 irq_req  out  1  IRQ request to CPU.
REQ-017 vec  out  16  vector address for the presented request.
REQ-018 src_id  out  3  index of the presented IRQ source; 0 when NMI is presented.
REQ-019 pend  out  NSRC  raw pending bits, readable status.

Function
REQ-020 Edge detect: nmi_pend SHALL set on nmi=1 with prev_nmi=0; prev_nmi SHALL update every ce cycle.
REQ-021 Edge source i: pend[i] SHALL set on rising edge of irq_in[i]; it SHALL clear only on clr_we with clr_d[i]=1, or on ack of source i. A set and a clear in the same cycle SHALL leave the bit set.
REQ-022 Level source i: pend[i] SHALL equal registered irq_in[i] (one-cycle latency); clr_d SHALL have no effect.
REQ-023 active = pend & mask; mask_we SHALL take effect the next cycle.
REQ-024 Priority: NMI over all IRQs; among IRQs the lowest index wins.
REQ-025 FSM states: IDLE, REQ, ACKD.
REQ-026 IDLE -> REQ when nmi_pend=1, or when |active=1 and i_flag=0; the selection and vector are latched on entry.
REQ-027 In REQ: nmi_req=1 if NMI is selected, otherwise irq_req=1; vec and src_id SHALL be held stable.
REQ-028 In REQ with an IRQ selected: if nmi_pend sets before ack, the selection SHALL switch to NMI (hijack): vec=16'hFFFA, src_id=0.
REQ-029 In REQ with an IRQ selected: if the selected source's active bit drops before ack, return to IDLE with requests deasserted (withdrawn); i_flag rising while in REQ SHALL NOT withdraw.
REQ-030 REQ -> ACKD on ack=1: clear nmi_pend if NMI selected, else clear pend[src_id] if that source is edge mode; nmi_req and irq_req SHALL drop in ACKD.
REQ-031 ACKD -> IDLE unconditionally after one ce cycle, giving a minimum one-cycle gap between requests.
REQ-032 ack outside REQ SHALL be ignored.
REQ-033 Vectors: NMI = 16'hFFFA; IRQ source i = VEC_BASE + 2*i (16-bit add, no wrap permitted per REQ-003).
REQ-034 ce=0 SHALL freeze all state, including edge samples; edges SHALL be detected on ce samples only.

Reset
REQ-035 On reset: state=IDLE; nmi_req=0, irq_req=0, vec=16'hFFFA, src_id=0; pend=0, nmi_pend=0, mask=0.
REQ-036 On reset, prev_nmi and prev_irq SHALL load the current nmi and irq_in values, so that lines already high at reset produce no edge.
REQ-037 Reset during REQ or ACKD SHALL abort immediately and discard any pending request; reset SHALL take effect regardless of ce.

Verification
REQ-038 mask=4'hF, i_flag=0, pulse irq_in[2] rising -> irq_req=1 within 2 cycles, vec=16'hFFF4, src_id=2; after ack, irq_req=0 and pend[2]=0.
REQ-039 irq_in[1] and irq_in[3] rise in the same cycle -> src_id=1 (vec=16'hFFF2) presented first; after ack plus one cycle, src_id=3 (vec=16'hFFF6).
REQ-040 IRQ source 0 in REQ, nmi rises before ack -> nmi_req=1, irq_req=0, vec=16'hFFFA; after ack, pend[0] is still 1 and is served next.
REQ-041 Level source 3 asserted then dropped before ack -> irq_req falls, FSM returns to IDLE, no ack required.
REQ-042 i_flag=1 with pend[0]=1 -> no irq_req; nmi rising edge -> nmi_req=1; i_flag set to 0 -> IRQ source 0 presented.
REQ-043 nmi held high through reset release -> no nmi_req; ce=0 while nmi rises -> edge detected on the first ce=1 sample.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge NMI plus NSRC maskable IRQ sources (edge or level per source),
// fixed priority, and an IDLE/REQ/ACKD handshake with the CPU including NMI hijack and IRQ withdrawal.
module irq_ctrl #(
    parameter int              NSRC      = 4,
    parameter logic [NSRC-1:0] EDGE_MASK = 4'b0011,
    parameter logic [15:0]     VEC_BASE  = 16'hFFF0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ce,
    input  logic            nmi,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_d,
    input  logic            clr_we,
    input  logic [NSRC-1:0] clr_d,
    input  logic            i_flag,
    input  logic            ack,
    output logic            nmi_req,
    output logic            irq_req,
    output logic [15:0]     vec,
    output logic [2:0]      src_id,
    output logic [NSRC-1:0] pend
);

    localparam logic [15:0] NMI_VEC = 16'hFFFA;

    if (NSRC < 1 || NSRC > 8) begin : g_bad_nsrc
        $error("irq_ctrl: NSRC must be in 1..8");
    end
    if (int'(VEC_BASE) + 2 * (NSRC - 1) >= 32'hFFFA) begin : g_bad_vec
        $error("irq_ctrl: IRQ vectors overlap the NMI vector");
    end

    typedef enum logic [1:0] {IDLE, REQ, ACKD} state_t;

    state_t          state_q, state_d;
    logic            sel_nmi_q, sel_nmi_d;
    logic [15:0]     vec_q, vec_d;
    logic [2:0]      src_id_q, src_id_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] msk_q, msk_d;
    logic            nmi_pend_q, nmi_pend_d;
    logic            prev_nmi_q;
    logic [NSRC-1:0] prev_irq_q;

    logic [NSRC-1:0] active;
    logic [NSRC-1:0] ack_clr;
    logic            nmi_ack;
    logic            sel_active;
    logic [2:0]      pick;

    assign active = pend_q & msk_q;
    assign msk_d  = mask_we ? mask_d : msk_q;

    // A set in the same cycle as a clear wins, so a fresh edge is never lost.
    assign nmi_pend_d = (nmi & ~prev_nmi_q) | (nmi_pend_q & ~nmi_ack);

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        if (EDGE_MASK[gi]) begin : g_edge
            assign pend_d[gi] = (irq_in[gi] & ~prev_irq_q[gi])
                              | (pend_q[gi] & ~((clr_we & clr_d[gi]) | ack_clr[gi]));
        end else begin : g_level
            assign pend_d[gi] = irq_in[gi];
        end
    end

    always_comb begin
        pick       = 3'd0;
        sel_active = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) pick = 3'(i);
            if (src_id_q == 3'(i) && active[i]) sel_active = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_nmi_d = sel_nmi_q;
        vec_d     = vec_q;
        src_id_d  = src_id_q;
        nmi_ack   = 1'b0;
        ack_clr   = '0;
        case (state_q)
            IDLE: begin
                if (nmi_pend_q) begin
                    state_d   = REQ;
                    sel_nmi_d = 1'b1;
                    vec_d     = NMI_VEC;
                    src_id_d  = 3'd0;
                end else if (|active && !i_flag) begin
                    state_d   = REQ;
                    sel_nmi_d = 1'b0;
                    vec_d     = VEC_BASE + {12'd0, pick, 1'b0};
                    src_id_d  = pick;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = ACKD;
                    if (sel_nmi_q) begin
                        nmi_ack = 1'b1;
                    end else begin
                        for (int i = 0; i < NSRC; i++) begin
                            if (src_id_q == 3'(i)) ack_clr[i] = 1'b1;
                        end
                    end
                end else if (!sel_nmi_q) begin
                    // NMI arriving mid-handshake steals the slot; a vanished IRQ is withdrawn.
                    if (nmi_pend_q) begin
                        sel_nmi_d = 1'b1;
                        vec_d     = NMI_VEC;
                        src_id_d  = 3'd0;
                    end else if (!sel_active) begin
                        state_d = IDLE;
                    end
                end
            end
            ACKD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_nmi_q  <= 1'b1;
            vec_q      <= NMI_VEC;
            src_id_q   <= 3'd0;
            pend_q     <= '0;
            msk_q      <= '0;
            nmi_pend_q <= 1'b0;
            prev_nmi_q <= nmi;
            prev_irq_q <= irq_in;
        end else if (ce) begin
            state_q    <= state_d;
            sel_nmi_q  <= sel_nmi_d;
            vec_q      <= vec_d;
            src_id_q   <= src_id_d;
            pend_q     <= pend_d;
            msk_q      <= msk_d;
            nmi_pend_q <= nmi_pend_d;
            prev_nmi_q <= nmi;
            prev_irq_q <= irq_in;
        end
    end

    assign nmi_req = (state_q == REQ) &&  sel_nmi_q;
    assign irq_req = (state_q == REQ) && !sel_nmi_q;
    assign vec     = vec_q;
    assign src_id  = src_id_q;
    assign pend    = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with default parameters (sources 0,1 edge; 2,3 level; base FFF0).
module tb_irq_ctrl;

    logic        clock = 1'b0;
    logic        reset, ce, nmi, mask_we, clr_we, i_flag, ack;
    logic [3:0]  irq_in, mask_d, clr_d, pend;
    logic        nmi_req, irq_req;
    logic [15:0] vec;
    logic [2:0]  src_id;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    irq_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .nmi     (nmi),
        .irq_in  (irq_in),
        .mask_we (mask_we),
        .mask_d  (mask_d),
        .clr_we  (clr_we),
        .clr_d   (clr_d),
        .i_flag  (i_flag),
        .ack     (ack),
        .nmi_req (nmi_req),
        .irq_req (irq_req),
        .vec     (vec),
        .src_id  (src_id),
        .pend    (pend)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_d = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; nmi = 1'b0; irq_in = 4'h0;
        mask_we = 1'b0; mask_d = 4'h0; clr_we = 1'b0; clr_d = 4'h0;
        i_flag = 1'b0; ack = 1'b0;
        tick(); tick();
        check("rst_nmi_req", 16'(nmi_req), 16'h0);
        check("rst_irq_req", 16'(irq_req), 16'h0);
        check("rst_vec", vec, 16'hFFFA);
        check("rst_src", 16'(src_id), 16'h0);
        check("rst_pend", 16'(pend), 16'h0);
        reset = 1'b0;
        set_mask(4'hF);

        // Single level source 2
        irq_in = 4'b0100; tick();
        check("s2_pend", 16'(pend), 16'h4);
        check("s2_no_req_yet", 16'(irq_req), 16'h0);
        tick();
        check("s2_irq_req", 16'(irq_req), 16'h1);
        check("s2_vec", vec, 16'hFFF4);
        check("s2_src", 16'(src_id), 16'h2);
        irq_in = 4'b0000; do_ack();
        check("s2_ackd_req", 16'(irq_req), 16'h0);
        check("s2_ackd_pend", 16'(pend), 16'h0);
        tick();

        // Sources 1 and 3 together: lower index first
        irq_in = 4'b1010; tick(); tick();
        check("p_first_src", 16'(src_id), 16'h1);
        check("p_first_vec", vec, 16'hFFF2);
        do_ack();
        check("p_gap_req", 16'(irq_req), 16'h0);
        check("p_pend_after", 16'(pend), 16'h8);
        tick(); tick();
        check("p_second_req", 16'(irq_req), 16'h1);
        check("p_second_src", 16'(src_id), 16'h3);
        check("p_second_vec", vec, 16'hFFF6);
        irq_in = 4'b0000; do_ack(); tick();
        check("p_done_pend", 16'(pend), 16'h0);

        // NMI hijacks an IRQ in REQ
        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick();
        check("h_irq_src0", 16'(irq_req), 16'h1);
        check("h_vec0", vec, 16'hFFF0);
        nmi = 1'b1; tick(); tick();
        check("h_nmi_req", 16'(nmi_req), 16'h1);
        check("h_irq_off", 16'(irq_req), 16'h0);
        check("h_vec", vec, 16'hFFFA);
        check("h_src", 16'(src_id), 16'h0);
        do_ack();
        check("h_pend0_kept", 16'(pend), 16'h1);
        check("h_ackd_nmi", 16'(nmi_req), 16'h0);
        tick(); tick();
        check("h_served_next", 16'(irq_req), 16'h1);
        check("h_served_vec", vec, 16'hFFF0);
        do_ack(); tick();
        nmi = 1'b0; tick();

        // Level source 3 withdrawn before ack
        irq_in = 4'b1000; tick(); tick();
        check("w_req", 16'(irq_req), 16'h1);
        check("w_src", 16'(src_id), 16'h3);
        irq_in = 4'b0000; tick(); tick();
        check("w_withdrawn", 16'(irq_req), 16'h0);
        tick();
        check("w_stays_idle", 16'(irq_req | nmi_req), 16'h0);

        // i_flag blocks IRQ but not NMI
        i_flag = 1'b1;
        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick(); tick();
        check("i_blocked", 16'(irq_req), 16'h0);
        check("i_pend0", 16'(pend), 16'h1);
        nmi = 1'b1; tick(); tick();
        check("i_nmi_req", 16'(nmi_req), 16'h1);
        do_ack(); nmi = 1'b0; tick();
        check("i_still_blocked", 16'(irq_req | nmi_req), 16'h0);
        i_flag = 1'b0; tick();
        check("i_irq0_req", 16'(irq_req), 16'h1);
        check("i_irq0_src", 16'(src_id), 16'h0);
        i_flag = 1'b1; tick(); tick();
        check("i_no_withdraw", 16'(irq_req), 16'h1);
        do_ack(); tick(); i_flag = 1'b0;

        // Pending clear on masked sources; set beats clear
        set_mask(4'h0);
        irq_in = 4'b1001; tick(); tick();
        check("c_pend", 16'(pend), 16'h9);
        check("c_masked", 16'(irq_req), 16'h0);
        clr_we = 1'b1; clr_d = 4'b1001; tick(); clr_we = 1'b0;
        check("c_cleared", 16'(pend), 16'h8);
        irq_in = 4'b1000; tick();
        irq_in = 4'b1001; clr_we = 1'b1; clr_d = 4'b0001; tick(); clr_we = 1'b0;
        check("c_set_wins", 16'(pend), 16'h9);

        // Reset aborts a live request
        set_mask(4'hF); tick();
        check("r_req_live", 16'(irq_req), 16'h1);
        irq_in = 4'b0000; reset = 1'b1; ce = 1'b0; tick();
        check("r_abort_req", 16'(irq_req), 16'h0);
        check("r_abort_pend", 16'(pend), 16'h0);
        check("r_abort_vec", vec, 16'hFFFA);
        ce = 1'b1;

        // NMI high through reset release; ce=0 freezes edge detection
        nmi = 1'b1; tick(); reset = 1'b0; tick(); tick();
        check("n_no_edge", 16'(nmi_req), 16'h0);
        nmi = 1'b0; tick();
        ce = 1'b0; nmi = 1'b1; tick(); tick();
        check("n_frozen", 16'(nmi_req), 16'h0);
        ce = 1'b1; tick(); tick();
        check("n_ce_edge", 16'(nmi_req), 16'h1);
        ack = 1'b1; ce = 1'b0; tick(); ack = 1'b0; ce = 1'b1;
        check("n_ack_frozen", 16'(nmi_req), 16'h1);
        do_ack();
        check("n_acked", 16'(nmi_req), 16'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
